// File: rtl/iact_addr_sram_sched_pkg.sv
// Shared constants and FSM encoding for the iact address SRAM scheduler.
package iact_addr_sram_sched_pkg;

  // Width of one CSC address word held in the iact address SRAM.
  localparam int unsigned IACT_ADDR_DATA_W = 7;
  // SRAM read address width; stream indices are zero-extended into it.
  localparam int unsigned SRAM_ADDR_W      = 10;
  // Cycles the SRAM needs after reset release to self-clear.
  localparam int unsigned INIT_CYCLES      = 4;

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StIdle  = 3'd1,
    StLoad  = 3'd2,
    StReady = 3'd3,
    StRead  = 3'd4,
    StGap   = 3'd5
  } state_e;

endpackage

// File: rtl/iact_addr_sram_sched_if.sv
// Scheduler <-> iact address SRAM bus. The scheduler is the master side.
interface iact_addr_sram_sched_if;
  import iact_addr_sram_sched_pkg::*;

  // Write path
  logic                        sram_write_en;
  logic                        sram_data_in_valid;
  logic [IACT_ADDR_DATA_W-1:0] sram_data_in;
  logic                        sram_data_in_ready;
  logic                        sram_write_done;

  // Read path
  logic                        sram_read_en;
  logic [SRAM_ADDR_W-1:0]      sram_read_addr;
  logic                        sram_data_out_ready;
  logic                        sram_data_out_valid;
  logic [IACT_ADDR_DATA_W-1:0] sram_data_out;
  logic                        sram_read_done;

  modport master (
    output sram_write_en,
    output sram_data_in_valid,
    output sram_data_in,
    input  sram_data_in_ready,
    input  sram_write_done,
    output sram_read_en,
    output sram_read_addr,
    output sram_data_out_ready,
    input  sram_data_out_valid,
    input  sram_data_out,
    input  sram_read_done
  );

  modport slave (
    input  sram_write_en,
    input  sram_data_in_valid,
    input  sram_data_in,
    output sram_data_in_ready,
    output sram_write_done,
    input  sram_read_en,
    input  sram_read_addr,
    input  sram_data_out_ready,
    output sram_data_out_valid,
    output sram_data_out,
    output sram_read_done
  );

endinterface

// File: rtl/iact_addr_sram_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found searching upward from i_ptr
// (wrapping) wins. Output is one-hot, or zero when nothing requests.
module iact_addr_sram_sched_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic w_found;

  // Walk priority offsets from the pointer; only constant indices touch the vectors.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && i_req[i] && (((32'(i_ptr) + off) % NUM_REQ) == i)) begin
          o_gnt[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iact_addr_sram_sched.sv
// Schedules one shared iact address SRAM between an upstream CSC loader and NUM_REQ PE
// readers. After reset the SRAM self-clears (INIT), then a load fills it; afterwards readers
// are served one whole stream at a time in round-robin order, with a one-cycle read-enable
// drop (GAP) between streams so the SRAM rewinds its read index.
module iact_addr_sram_sched
  import iact_addr_sram_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned LUT_IDX_W = 5
) (
  input  logic                           i_clock,
  input  logic                           i_reset,       // synchronous, active-low
  // Upstream CSC address load
  input  logic                           i_load_start,
  input  logic                           i_load_valid,
  input  logic [IACT_ADDR_DATA_W-1:0]    i_load_data,
  output logic                           o_load_ready,
  // PE read requesters
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*LUT_IDX_W-1:0]   i_req_stream,
  input  logic [NUM_REQ-1:0]             i_rsp_ready,
  output logic [NUM_REQ-1:0]             o_gnt,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [NUM_REQ-1:0]             o_rsp_done,
  output logic [IACT_ADDR_DATA_W-1:0]    o_rsp_data,
  output logic                           o_busy,
  // SRAM side
  iact_addr_sram_sched_if.master         io_sram
);

  localparam int unsigned PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0]  InitLast = 2'(INIT_CYCLES - 1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [1:0]             r_init_cnt;
  logic [PtrW-1:0]        r_rr_ptr;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [PtrW-1:0]        r_gnt_idx;
  logic [LUT_IDX_W-1:0]   r_stream;
  logic                   r_loaded;

  logic [NUM_REQ-1:0]     w_arb_gnt;
  logic [PtrW-1:0]        w_arb_idx;
  logic [LUT_IDX_W-1:0]   w_arb_stream;
  logic                   w_grant_take;
  logic                   w_read_end;
  logic                   w_data_nonzero;

  iact_addr_sram_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_rr_arbiter (
    .i_req (i_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt)
  );

  // Decode the arbiter's one-hot winner into an index and its requested stream.
  always_comb begin
    w_arb_idx    = '0;
    w_arb_stream = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_arb_idx    = PtrW'(i);
        w_arb_stream = i_req_stream[i*LUT_IDX_W +: LUT_IDX_W];
      end
    end
  end

  assign w_grant_take   = (r_state == StReady) && (w_state_next == StRead);
  assign w_read_end     = (r_state == StRead) && io_sram.sram_read_done;
  assign w_data_nonzero = (io_sram.sram_data_out != '0);

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: load requests beat read requests in READY; load_start elsewhere is dropped.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInit:  if (r_init_cnt == InitLast) w_state_next = StIdle;
      StIdle:  if (i_load_start) w_state_next = StLoad;
      StLoad:  if (io_sram.sram_write_done) w_state_next = StReady;
      StReady: begin
        if (i_load_start) begin
          w_state_next = StLoad;
        end else if ((|i_req) && r_loaded) begin
          w_state_next = StRead;
        end
      end
      StRead:  if (io_sram.sram_read_done) w_state_next = StGap;
      StGap:   w_state_next = StReady;
      default: w_state_next = StInit;
    endcase
  end

  // Init counter, loaded flag, grant/stream latch and round-robin pointer.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_init_cnt <= '0;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_stream   <= '0;
      r_loaded   <= 1'b0;
    end else begin
      if (r_state == StInit) begin
        r_init_cnt <= r_init_cnt + 2'd1;
      end
      if ((r_state == StLoad) && io_sram.sram_write_done) begin
        r_loaded <= 1'b1;
      end
      // Grant is held for the whole stream even if the requester drops req meanwhile.
      if (w_grant_take) begin
        r_gnt     <= w_arb_gnt;
        r_gnt_idx <= w_arb_idx;
        r_stream  <= w_arb_stream;
      end
      if (w_read_end) begin
        r_gnt    <= '0;
        r_rr_ptr <= (r_gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : r_gnt_idx + PtrW'(1);
      end
    end
  end

  // FSM outputs: every SRAM control not owned by the current state is held at zero.
  always_comb begin
    o_load_ready                = 1'b0;
    o_rsp_valid                 = '0;
    o_rsp_done                  = '0;
    io_sram.sram_write_en       = 1'b0;
    io_sram.sram_data_in_valid  = 1'b0;
    io_sram.sram_data_in        = '0;
    io_sram.sram_read_en        = 1'b0;
    io_sram.sram_read_addr      = '0;
    io_sram.sram_data_out_ready = 1'b0;
    unique case (r_state)
      StLoad: begin
        io_sram.sram_write_en      = 1'b1;
        io_sram.sram_data_in_valid = i_load_valid;
        io_sram.sram_data_in       = i_load_data;
        o_load_ready               = io_sram.sram_data_in_ready;
      end
      StRead: begin
        io_sram.sram_read_en        = 1'b1;
        io_sram.sram_read_addr      = SRAM_ADDR_W'(r_stream);
        io_sram.sram_data_out_ready = |(r_gnt & i_rsp_ready);
        // Zero words terminate a stream and are never handed to the PE.
        o_rsp_valid = r_gnt & {NUM_REQ{io_sram.sram_data_out_valid & w_data_nonzero}};
        o_rsp_done  = r_gnt & {NUM_REQ{io_sram.sram_read_done}};
      end
      default: ;
    endcase
  end

  assign o_gnt      = r_gnt;
  assign o_rsp_data = io_sram.sram_data_out;
  assign o_busy     = (r_state != StReady);

endmodule

// File: tb/tb_iact_addr_sram_sched.sv
// Bench for iact_addr_sram_sched: directed scenarios with literal expectations, then a random
// phase, all outputs compared every cycle against a phase-level behavioural model.
module tb_iact_addr_sram_sched;
  import iact_addr_sram_sched_pkg::*;

  localparam int NReq = 3;
  localparam int LutW = 5;

  localparam int PhInit  = 0;
  localparam int PhIdle  = 1;
  localparam int PhLoad  = 2;
  localparam int PhReady = 3;
  localparam int PhRead  = 4;
  localparam int PhGap   = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 load_start;
  logic                 load_valid;
  logic [6:0]           load_data;
  logic                 load_ready;
  logic [NReq-1:0]      req;
  logic [NReq*LutW-1:0] req_stream;
  logic [NReq-1:0]      rsp_ready;
  logic [NReq-1:0]      gnt;
  logic [NReq-1:0]      rsp_valid;
  logic [NReq-1:0]      rsp_done;
  logic [6:0]           rsp_data;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  iact_addr_sram_sched_if u_sram_if ();

  iact_addr_sram_sched #(
    .NUM_REQ   (NReq),
    .LUT_IDX_W (LutW)
  ) u_dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_load_start (load_start),
    .i_load_valid (load_valid),
    .i_load_data  (load_data),
    .o_load_ready (load_ready),
    .i_req        (req),
    .i_req_stream (req_stream),
    .i_rsp_ready  (rsp_ready),
    .o_gnt        (gnt),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_done   (rsp_done),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy),
    .io_sram      (u_sram_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (bound expired) at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin pick: first requester at or after p, wrapping.
  function automatic int pick(input logic [NReq-1:0] r, input int p);
    logic [NReq-1:0] t;
    for (int k = 0; k < NReq; k++) begin
      t = r >> ((p + k) % NReq);
      if (t[0]) return (p + k) % NReq;
    end
    return 0;
  endfunction

  function automatic logic [LutW-1:0] stream_of(input logic [NReq*LutW-1:0] s, input int idx);
    logic [NReq*LutW-1:0] t;
    t = s >> (LutW * idx);
    return t[LutW-1:0];
  endfunction

  // Behavioural model: which phase the scheduler is in, who owns the SRAM, and where the
  // next round-robin search starts.
  int              m_phase;
  int              m_init_left;
  int              m_owner;
  int              m_ptr;
  logic [LutW-1:0] m_stream;
  bit              m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase     <= PhInit;
      m_init_left <= 3;          // four INIT cycles after release
      m_owner     <= -1;
      m_ptr       <= 0;
      m_stream    <= '0;
      m_valid     <= 1'b1;
    end else begin
      case (m_phase)
        PhInit: begin
          if (m_init_left == 0) m_phase <= PhIdle;
          else m_init_left <= m_init_left - 1;
        end
        PhIdle:  if (load_start) m_phase <= PhLoad;
        PhLoad:  if (u_sram_if.sram_write_done) m_phase <= PhReady;
        PhReady: begin
          if (load_start) begin
            m_phase <= PhLoad;
          end else if (req != '0) begin
            m_phase  <= PhRead;
            m_owner  <= pick(req, m_ptr);
            m_stream <= stream_of(req_stream, pick(req, m_ptr));
          end
        end
        PhRead: begin
          if (u_sram_if.sram_read_done) begin
            m_phase <= PhGap;
            m_ptr   <= (m_owner + 1) % NReq;
            m_owner <= -1;
          end
        end
        PhGap:   m_phase <= PhReady;
        default: m_phase <= PhInit;
      endcase
    end
  end

  // Compare every DUT output against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    bit              in_load;
    bit              in_read;
    logic [NReq-1:0] own;
    if (m_valid) begin
      in_load = (m_phase == PhLoad);
      in_read = (m_phase == PhRead);
      own     = in_read ? NReq'(1 << m_owner) : '0;
      check("busy", busy, 32'(m_phase != PhReady));
      check("load_ready", load_ready, 32'(in_load && u_sram_if.sram_data_in_ready));
      check("sram_write_en", u_sram_if.sram_write_en, 32'(in_load));
      check("sram_data_in_valid", u_sram_if.sram_data_in_valid, 32'(in_load && load_valid));
      check("sram_data_in", u_sram_if.sram_data_in, in_load ? 32'(load_data) : 0);
      check("sram_read_en", u_sram_if.sram_read_en, 32'(in_read));
      check("sram_read_addr", u_sram_if.sram_read_addr, in_read ? 32'(m_stream) : 0);
      check("gnt", gnt, 32'(own));
      check("sram_data_out_ready", u_sram_if.sram_data_out_ready, 32'((own & rsp_ready) != 0));
      check("rsp_valid", rsp_valid,
            (u_sram_if.sram_data_out_valid && u_sram_if.sram_data_out != 0) ? 32'(own) : 0);
      check("rsp_done", rsp_done, u_sram_if.sram_read_done ? 32'(own) : 0);
      check("rsp_data", rsp_data, 32'(u_sram_if.sram_data_out));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  logic [6:0] beats [6] = '{7'd3, 7'd5, 7'd0, 7'd7, 7'd0, 7'd0};
  logic [6:0] items [2] = '{7'd3, 7'd5};

  initial begin
    bit   acc;
    bit   tog;
    logic rdy;
    int   tries;
    int   delivered;
    int   done_seen;
    int   item;
    int   guard;

    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    req = '0; req_stream = '0; rsp_ready = '0;
    u_sram_if.sram_data_in_ready  = 1'b0;
    u_sram_if.sram_write_done     = 1'b0;
    u_sram_if.sram_data_out_valid = 1'b0;
    u_sram_if.sram_data_out       = '0;
    u_sram_if.sram_read_done      = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 1);
    check("rst_gnt", gnt, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_read_addr", u_sram_if.sram_read_addr, 0);

    // load_start during INIT is dropped; in IDLE it starts a load next cycle
    rst_n = 1'b1;                                   // cycle 0
    tick(); tick(); load_start = 1'b1;              // cycle 2
    tick(); load_start = 1'b0; tick();              // cycle 4
    check("init_ignores_load_start", u_sram_if.sram_write_en, 0);
    tick(); tick(); load_start = 1'b1;              // cycle 6
    tick(); load_start = 1'b0;                      // cycle 7
    check("idle_load_start_to_load", u_sram_if.sram_write_en, 1);

    // Load {3,5,0,7,0,0} with a randomly stalling SRAM
    for (int b = 0; b < 6; b++) begin
      acc = 1'b0; tries = 0;
      while (!acc && tries < 50) begin
        rdy = 1'($urandom_range(0, 1));
        load_valid = 1'b1; load_data = beats[b];
        u_sram_if.sram_data_in_ready = rdy;
        #1;
        check("load_ready_mirror", load_ready, 32'(rdy));
        acc = rdy; tries++;
        tick();
      end
      if (!acc) fail_now("load_beat_accept");
    end
    load_valid = 1'b0; u_sram_if.sram_data_in_ready = 1'b0;
    u_sram_if.sram_write_done = 1'b1;
    tick();
    u_sram_if.sram_write_done = 1'b0;
    check("write_done_to_ready_busy", busy, 0);

    // All three request stream 0: served 001, 010, 100, each followed by a GAP
    req = 3'b111; req_stream = '0;
    for (int g = 0; g < NReq; g++) begin
      tick();
      check("grant_order", gnt, 32'(1 << g));
      check("grant_stream0_addr", u_sram_if.sram_read_addr, 0);
      delivered = 0; done_seen = 0; tog = 1'b1; item = 0; guard = 0;
      while (item < 2 && guard < 20) begin
        rsp_ready = tog ? NReq'(1 << g) : ~NReq'(1 << g);
        u_sram_if.sram_data_out_valid = 1'b1;
        u_sram_if.sram_data_out = items[item];
        #1;
        check("data_out_ready_follows", u_sram_if.sram_data_out_ready, 32'(tog));
        if (tog && rsp_valid == NReq'(1 << g)) begin
          delivered++;
          item++;
        end
        if (rsp_done != '0) done_seen++;
        tog = ~tog; guard++;
        tick();
      end
      u_sram_if.sram_data_out = '0;
      rsp_ready = NReq'(1 << g);
      u_sram_if.sram_read_done = 1'b1;
      #1;
      check("terminator_not_forwarded", rsp_valid, 0);
      check("rsp_done_pulse", rsp_done, 32'(1 << g));
      tick();
      u_sram_if.sram_read_done = 1'b0;
      u_sram_if.sram_data_out_valid = 1'b0;
      req[g] = 1'b0;
      check("gap_gnt", gnt, 0);
      check("gap_read_en", u_sram_if.sram_read_en, 0);
      check("delivered_count", delivered, 2);
      check("no_early_done", done_seen, 0);
      tick();                                        // back in READY
    end

    // load_start and req[1] together in READY: load wins, req[1] served afterwards
    load_start = 1'b1; req = 3'b010; req_stream = 15'(7 << LutW);
    tick();
    load_start = 1'b0;
    check("load_priority_write_en", u_sram_if.sram_write_en, 1);
    check("load_priority_gnt", gnt, 0);
    u_sram_if.sram_write_done = 1'b1;
    tick();
    u_sram_if.sram_write_done = 1'b0;
    check("reload_ready_busy", busy, 0);
    tick();
    check("req1_after_load_gnt", gnt, 3'b010);
    check("req1_stream_addr", u_sram_if.sram_read_addr, 7);
    u_sram_if.sram_read_done = 1'b1;
    #1;
    check("req1_done", rsp_done, 3'b010);
    tick();
    u_sram_if.sram_read_done = 1'b0; req = '0;
    tick();

    // Reset in the middle of a read abandons it and re-enters INIT for four cycles
    req = 3'b001; req_stream = 15'd9;
    tick();
    check("pre_reset_gnt", gnt, 3'b001);
    u_sram_if.sram_data_out_valid = 1'b1; u_sram_if.sram_data_out = 7'd4; rsp_ready = 3'b111;
    rst_n = 1'b0;
    tick();
    check("reset_mid_read_gnt", gnt, 0);
    check("reset_mid_read_done", rsp_done, 0);
    check("reset_mid_read_valid", rsp_valid, 0);
    check("reset_rsp_data_passthrough", rsp_data, 4);
    req = '0; u_sram_if.sram_data_out_valid = 1'b0;
    rst_n = 1'b1;                                   // cycle 0
    tick(); tick(); tick(); load_start = 1'b1;      // cycle 3, still INIT
    tick();                                         // cycle 4, IDLE
    check("reinit_ignores_cycle3", u_sram_if.sram_write_en, 0);
    tick(); load_start = 1'b0;                      // cycle 5
    check("reinit_load_after_4", u_sram_if.sram_write_en, 1);
    u_sram_if.sram_write_done = 1'b1;
    tick();
    u_sram_if.sram_write_done = 1'b0;

    // Random traffic, checked by the per-cycle compare against the model
    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom_range(0, 399) != 0);
      load_start = ($urandom_range(0, 24) == 0);
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 7'($urandom);
      u_sram_if.sram_data_in_ready  = 1'($urandom_range(0, 1));
      u_sram_if.sram_write_done     = ($urandom_range(0, 5) == 0);
      u_sram_if.sram_data_out_valid = 1'($urandom_range(0, 1));
      u_sram_if.sram_data_out       = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
      u_sram_if.sram_read_done      = ($urandom_range(0, 5) == 0);
      rsp_ready = NReq'($urandom);
      for (int i = 0; i < NReq; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_stream[i*LutW +: LutW] = LutW'($urandom);
          end
        end else if ($urandom_range(0, 11) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end

    rst_n = 1'b1; load_start = 1'b0; req = '0;
    u_sram_if.sram_write_done = 1'b0; u_sram_if.sram_read_done = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
